// File: rtl/pll_reset_sequencer_pkg.sv
// Shared definitions for the PLL reset sequencer family: FSM encoding and clock-enable divider field width.
package pll_reset_sequencer_pkg;

  localparam int CE_DIV_W = 16;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_STAB = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // A programmed divider of 0 behaves exactly like 1 (enable every cycle).
  function automatic logic [CE_DIV_W-1:0] eff_div(input logic [CE_DIV_W-1:0] div);
    return (div == '0) ? CE_DIV_W'(1) : div;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_ce_divider.sv
// One clock-enable channel: pulses on the first RUN cycle, then every DIV cycles; held at phase 0 outside RUN.
// Output is a decode of registers only (run is the registered ready flag).
module ce_divider
  import pll_reset_sequencer_pkg::*;
#(
  parameter logic [CE_DIV_W-1:0] DIV = 16'd1
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  output logic ce
);

  localparam logic [CE_DIV_W-1:0] LAST = eff_div(DIV) - CE_DIV_W'(1);

  logic [CE_DIV_W-1:0] div_cnt_q, div_cnt_d;

  always_comb begin
    div_cnt_d = '0;
    if (run) begin
      div_cnt_d = (div_cnt_q == LAST) ? '0 : div_cnt_q + CE_DIV_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  assign ce = run & (div_cnt_q == '0);

endmodule

// File: rtl/pll_reset_sequencer.sv
// Turns the asynchronous PLL lock flag into a clean system reset released after STABLE_CYCLES of stable lock,
// drives NUM_CE clock-enable channels in RUN and counts lock-loss events (saturating).
module pll_reset_sequencer
  import pll_reset_sequencer_pkg::*;
#(
  parameter int                         STABLE_CYCLES = 1024,
  parameter int                         NUM_CE        = 2,
  parameter logic [NUM_CE*CE_DIV_W-1:0] CE_DIVS       = {16'd4, 16'd1}
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pll_lock,
  output logic              sys_reset,
  output logic              ready,
  output logic [NUM_CE-1:0] ce,
  output logic [7:0]        relock_count
);

  localparam int                STAB_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);

  logic              sync1_q, lock_s_q;
  state_e            state_q, state_d;
  logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
  logic              sys_reset_q, sys_reset_d;
  logic              ready_q, ready_d;
  logic [7:0]        relock_q, relock_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q     <= 1'b0;
      lock_s_q    <= 1'b0;
      state_q     <= ST_WAIT;
      stab_cnt_q  <= '0;
      sys_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      relock_q    <= '0;
    end else begin
      sync1_q     <= pll_lock;
      lock_s_q    <= sync1_q;
      state_q     <= state_d;
      stab_cnt_q  <= stab_cnt_d;
      sys_reset_q <= sys_reset_d;
      ready_q     <= ready_d;
      relock_q    <= relock_d;
    end
  end

  // Loss of lock takes priority over reaching the stability target.
  always_comb begin
    state_d    = state_q;
    stab_cnt_d = '0;
    case (state_q)
      ST_WAIT: begin
        if (lock_s_q) state_d = ST_STAB;
      end
      ST_STAB: begin
        if (!lock_s_q) begin
          state_d = ST_WAIT;
        end else if (stab_cnt_q == STAB_LAST) begin
          state_d = ST_RUN;
        end else begin
          stab_cnt_d = stab_cnt_q + STAB_W'(1);
        end
      end
      ST_RUN: begin
        if (!lock_s_q) state_d = ST_WAIT;
      end
      default: state_d = ST_WAIT;
    endcase
  end

  always_comb begin
    sys_reset_d = (state_d != ST_RUN);
    ready_d     = (state_d == ST_RUN);
    relock_d    = relock_q;
    if ((state_q == ST_RUN) && !lock_s_q && (relock_q != 8'hFF)) begin
      relock_d = relock_q + 8'd1;
    end
  end

  for (genvar i = 0; i < NUM_CE; i++) begin : g_ce
    ce_divider #(
      .DIV(CE_DIVS[CE_DIV_W*i +: CE_DIV_W])
    ) u_ce_divider (
      .clock(clock),
      .reset(reset),
      .run  (ready_q),
      .ce   (ce[i])
    );
  end

  assign sys_reset    = sys_reset_q;
  assign ready        = ready_q;
  assign relock_count = relock_q;

endmodule
